// File: rtl/wb_trace_uart.sv
// wb_trace_uart
//   Observes the CPU debug write-back bus and ships every register-writing
//   retirement to a host over an 8N1 UART, as one 72-bit record per event:
//     [71:40] pc, [39:37] 3'b000, [36:32] rf addr, [31:0] wdata
//   The record goes out most-significant byte first, each byte LSB first.
//   Events are queued in a FIFO. The CPU is never stalled: an event that
//   arrives while the FIFO is full is dropped and 'overflow' is latched.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   debug_wb_pc         PC of the retiring instruction
//   debug_wb_rf_wen     register-file write enable
//   debug_wb_rf_addr    destination register (writes to $0 are ignored)
//   debug_wb_rf_wdata   write-back data
//   uart_tx             registered serial line, idles high
//   tx_busy             FIFO non-empty or serializer active
//   overflow            sticky: an event was dropped
//   rec_count           records fully sent (wraps at 16 bits)
module wb_trace_uart #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] debug_wb_pc,
  input  logic        debug_wb_rf_wen,
  input  logic [4:0]  debug_wb_rf_addr,
  input  logic [31:0] debug_wb_rf_wdata,
  output logic        uart_tx,
  output logic        tx_busy,
  output logic        overflow,
  output logic [15:0] rec_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  pad;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } rec_t;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------------------------------------------------------- FIFO
  rec_t          fifo_mem [FIFO_DEPTH];
  rec_t          rec_in;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          capture, full, push, pop;

  // ------------------------------------------------------------ serializer
  state_t        state_q, state_d;
  logic [71:0]   shreg_q, shreg_d;
  logic [3:0]    byte_idx_q, byte_idx_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [15:0]   rec_count_q, rec_count_d;
  logic          uart_tx_q, uart_tx_d;
  logic          baud_done;
  logic [7:0]    cur_byte;

  assign capture = debug_wb_rf_wen && (|debug_wb_rf_addr);
  // Fullness is judged on the count at the start of the cycle, so a pop in
  // the same cycle cannot make room for a push into a full FIFO.
  assign full    = (count_q == DEPTH_C);
  assign push    = capture && !full;
  assign pop     = (state_q == S_IDLE) && (count_q != '0);
  assign rec_in  = {debug_wb_pc, 3'b000, debug_wb_rf_addr, debug_wb_rf_wdata};

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    overflow_d = overflow_q | (capture & full);
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= rec_in;
  end

  // The byte on the wire is always the top byte; the register shifts left
  // by one byte after each stop bit.
  assign cur_byte  = shreg_q[71:64];
  assign baud_done = (baud_q == BAUD_LAST);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    byte_idx_d  = byte_idx_q;
    bit_idx_d   = bit_idx_q;
    baud_d      = baud_q;
    rec_count_d = rec_count_q;
    uart_tx_d   = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          shreg_d    = fifo_mem[rd_ptr_q];
          byte_idx_d = '0;
          bit_idx_d  = '0;
          baud_d     = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        uart_tx_d = 1'b0;
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        uart_tx_d = cur_byte[bit_idx_q];
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        uart_tx_d = 1'b1;
        if (baud_done) begin
          baud_d = '0;
          if (byte_idx_q == 4'd8) begin
            rec_count_d = rec_count_q + 1'b1;
            state_d     = S_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            shreg_d    = {shreg_q[63:0], 8'h00};
            state_d    = S_START;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      byte_idx_q  <= '0;
      bit_idx_q   <= '0;
      baud_q      <= '0;
      rec_count_q <= '0;
      uart_tx_q   <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      byte_idx_q  <= byte_idx_d;
      bit_idx_q   <= bit_idx_d;
      baud_q      <= baud_d;
      rec_count_q <= rec_count_d;
      uart_tx_q   <= uart_tx_d;
    end
  end

  assign uart_tx   = uart_tx_q;
  assign tx_busy   = (count_q != '0) || (state_q != S_IDLE);
  assign overflow  = overflow_q;
  assign rec_count = rec_count_q;

endmodule

// File: tb/tb_wb_trace_uart.sv
// Bench for wb_trace_uart (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Reference model: each accepted event is popped at
//   max(capture_edge + 1, previous_pop + 90*CPB + 1)
// and its start bit falls one edge later. FIFO occupancy at a capture edge
// is the number of accepted records whose pop edge is not yet earlier than
// that edge. A line monitor decodes records and checks them in order.
module tb_wb_trace_uart;
  localparam int CPB     = 4;
  localparam int DEPTH   = 4;
  localparam int REC_CYC = 90 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] debug_wb_pc = '0;
  logic        debug_wb_rf_wen = 1'b0;
  logic [4:0]  debug_wb_rf_addr = '0;
  logic [31:0] debug_wb_rf_wdata = '0;
  logic        uart_tx, tx_busy, overflow;
  logic [15:0] rec_count;

  wb_trace_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_addr(debug_wb_rf_addr), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .uart_tx(uart_tx), .tx_busy(tx_busy), .overflow(overflow), .rec_count(rec_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------- model
  typedef struct { logic [71:0] rec; int fall; } exp_t;
  exp_t exp_q[$];
  int   pop_edges[$];
  int   last_pop = -100000;
  logic exp_ovf = 1'b0;
  int   acc_cnt = 0;

  function automatic void model_reset();
    exp_q.delete();
    pop_edges.delete();
    last_pop = -100000;
    exp_ovf  = 1'b0;
    acc_cnt  = 0;
  endfunction

  function automatic void model_capture(input int e, input logic [71:0] r);
    int occ, p;
    occ = 0;
    foreach (pop_edges[i]) if (pop_edges[i] >= e) occ++;
    if (occ >= DEPTH) exp_ovf = 1'b1;
    else begin
      p = (e + 1 > last_pop + REC_CYC + 1) ? e + 1 : last_pop + REC_CYC + 1;
      last_pop = p;
      pop_edges.push_back(p);
      exp_q.push_back('{rec: r, fall: p + 1});
      acc_cnt++;
    end
  endfunction

  // ---------------------------------------------------------- stimulus
  // Called at a falling edge; the inputs are sampled at edge cyc+1.
  task automatic drive(input logic wen, input logic [4:0] addr,
                       input logic [31:0] pc, input logic [31:0] wd);
    debug_wb_rf_wen   = wen;
    debug_wb_rf_addr  = addr;
    debug_wb_pc       = pc;
    debug_wb_rf_wdata = wd;
    if (wen && addr != 5'd0) model_capture(cyc + 1, {pc, 3'b000, addr, wd});
    @(negedge clk);
    chk("overflow", overflow, exp_ovf);
  endtask

  task automatic run_to(input int e);
    debug_wb_rf_wen = 1'b0;
    while (cyc < e) @(negedge clk);
  endtask

  task automatic drain();
    run_to(last_pop + REC_CYC + 2);
    run_to(cyc + 2);
    chk("busy_after_drain", tx_busy, 1'b0);
    chk("rec_count", rec_count, acc_cnt);
    chk("pending_records", exp_q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    debug_wb_rf_wen = 1'b0;
    model_reset();
    repeat (n) @(negedge clk);
  endtask

  // ----------------------------------------------------------- monitor
  initial begin : mon
    logic        prev;
    int          f, w, ferr;
    logic [71:0] got;
    bit          abort;
    exp_t        e;
    prev = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!reset && prev && uart_tx === 1'b0) begin
        f = cyc; got = '0; ferr = 0; abort = 0;
        for (int k = 0; k < 90 && !abort; k++) begin
          w = (k == 0) ? CPB / 2 : CPB;
          repeat (w) begin @(posedge clk); #1; if (reset) abort = 1; end
          if (!abort) begin
            if (k % 10 == 0) begin
              if (uart_tx !== 1'b0) ferr++;
            end else if (k % 10 == 9) begin
              if (uart_tx !== 1'b1) ferr++;
            end else begin
              got[64 - 8 * (k / 10) + (k % 10 - 1)] = uart_tx;
            end
          end
        end
        if (!abort) begin
          chk("rec_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("framing", ferr, 0);
            chk("rec_data", got, e.rec);
            chk("fall_edge", f, e.fall);
          end
        end
      end
      prev = uart_tx;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1);
  end

  // -------------------------------------------------------------- main
  initial begin : main
    int c, f, lows, highs, nsync;
    logic        wen;
    logic [4:0]  addr;

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1'b1);
    chk("rst_tx_busy", tx_busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_rec_count", rec_count, 16'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single record with latency and completion timing.
    c = cyc + 1;
    drive(1'b1, 5'd8, 32'hBFC0_0000, 32'h1234_5678);
    f = c + 2;
    chk("busy_after_capture", tx_busy, 1'b1);
    run_to(f - 1);
    chk("tx_before_fall", uart_tx, 1'b1);
    run_to(f);
    chk("tx_fall", uart_tx, 1'b0);
    nsync = 0;
    for (int t = f + 1; t <= f + 361; t++) begin
      run_to(t);
      if ((rec_count == 16'd0) != tx_busy) nsync++;
      if (t == f + 300) begin
        chk("mid_rec_count", rec_count, 16'd0);
        chk("mid_busy", tx_busy, 1'b1);
      end
    end
    chk("busy_cnt_same_edge", nsync, 0);
    chk("end_rec_count", rec_count, 16'd1);
    chk("end_busy", tx_busy, 1'b0);
    drain();

    // Writes to $0 and non-writing retirements are ignored.
    drive(1'b1, 5'd0, $urandom, $urandom);
    drive(1'b0, 5'd5, $urandom, $urandom);
    lows = 0; highs = 0;
    repeat (20) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
      if (tx_busy !== 1'b0) highs++;
    end
    chk("ignored_no_start", lows, 0);
    chk("ignored_no_busy", highs, 0);
    chk("ignored_rec_count", rec_count, acc_cnt);

    // Back-to-back: the second push lands on the IDLE pop cycle (count=1).
    drive(1'b1, 5'd3, 32'h0000_1000, 32'hA5A5_5A5A);
    drive(1'b1, 5'd31, 32'h0000_1004, 32'hFFFF_0001);
    chk("b2b_overflow", overflow, 1'b0);
    drain();

    // Overflow: serializer busy, six consecutive captures into depth 4.
    drive(1'b1, 5'd1, 32'h2000_0000, 32'h1111_1111);
    run_to(cyc + 10);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'(i + 10), 32'h3000_0000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      if (i == 3) chk("ovf_after_4th", overflow, 1'b0);
      if (i == 4) chk("ovf_after_5th", overflow, 1'b1);
    end
    drain();
    chk("ovf_sticky", overflow, 1'b1);

    // Reset during DATA of byte 3, with records still queued.
    do_reset(2);
    reset = 1'b0;
    @(negedge clk);
    c = cyc + 1;
    drive(1'b1, 5'd7, 32'h4000_0000, 32'hDEAD_BEEF);
    drive(1'b1, 5'd8, 32'h4000_0004, 32'h0BAD_F00D);
    drive(1'b1, 5'd9, 32'h4000_0008, 32'h0000_0001);
    f = c + 2;
    run_to(f + 129);
    do_reset(1);
    chk("rst_mid_uart_tx", uart_tx, 1'b1);
    chk("rst_mid_busy", tx_busy, 1'b0);
    chk("rst_mid_overflow", overflow, 1'b0);
    chk("rst_mid_rec_count", rec_count, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    run_to(cyc + 5);
    drive(1'b1, 5'd12, 32'h5000_0000, 32'h8765_4321);
    drain();

    // Randomized bursts.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) begin
        wen  = 1'($urandom_range(0, 1));
        addr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        drive(wen, addr, $urandom, $urandom);
      end
      if (r == 1) begin
        run_to(cyc + $urandom_range(50, 400));
        for (int i = 0; i < 8; i++) drive(1'b1, 5'($urandom_range(1, 31)), $urandom, $urandom);
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
